morse_decoder: RTL and testbench
================================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 The module SHALL have parameter UNIT_CYCLES, default 25000000, giving the clock cycles in one Morse time unit (0.5 s at 50 MHz).
REQ-002 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port led_in, input, 1 bit: the Morse light stream from the encoder LEDR output, synchronous to clk.
REQ-005 Port letter, output, 3 bits: decoded letter index, 0=A through 7=H.
REQ-006 Port valid, output, 1 bit: one-cycle pulse; letter holds a new result.
REQ-007 Port err, output, 1 bit: one-cycle pulse; the current symbol sequence is malformed.
REQ-008 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 led_in SHALL be registered once (led_q); all timing SHALL be measured on led_q, which adds 1 cycle of input latency.
REQ-010 A cycle counter SHALL count the cycles of the current led_q level; it SHALL clear on each led_q transition and saturate at 5*UNIT_CYCLES.
REQ-011 States SHALL be IDLE, MARK, SPACE and ERR.
REQ-012 IDLE: a rise of led_q SHALL enter MARK and clear the symbol count.
REQ-013 MARK, on a fall of led_q with high length L: L < UNIT/2 -> ERR; UNIT/2 <= L < 2*UNIT -> shift in dot (0); 2*UNIT <= L <= 4*UNIT -> shift in dash (1). A valid symbol SHALL enter SPACE.
REQ-014 MARK: when L exceeds 4*UNIT while led_q is still high, the block SHALL enter ERR immediately.
REQ-015 Symbols SHALL shift in MSB-first into a 4-bit register with a 3-bit symbol count (0..4); a fifth symbol SHALL enter ERR.
REQ-016 SPACE: a rise of led_q before the low length reaches 3*UNIT SHALL enter MARK; the threshold test SHALL use the counter value before the edge.
REQ-017 SPACE: when the low length reaches 3*UNIT, the block SHALL look up (count, pattern) and return to IDLE.
REQ-018 The lookup SHALL decode A=.- B=-... C=-.-. D=-.. E=. F=..-. G=--. H=....; on a match, letter SHALL update and valid SHALL pulse the next cycle.
REQ-019 Any other (count, pattern) combination SHALL pulse err instead of valid.
REQ-020 Latency SHALL be exactly 3*UNIT_CYCLES+2 cycles from the last falling edge of led_in to valid or err.
REQ-021 ERR: err SHALL pulse once on entry; the block SHALL leave ERR for IDLE only after led_q has been low for 3*UNIT continuously; rises in ERR SHALL restart that wait.
REQ-022 letter SHALL hold its last decoded value between valid pulses; valid and err SHALL never be high in the same cycle.

Reset
REQ-023 On reset the block SHALL enter IDLE and clear the counter, symbol register, symbol count and led_q; letter=0, valid=0, err=0, busy=0 the following cycle.
REQ-024 Reset SHALL override every state, including mid-MARK and mid-SPACE, and SHALL discard partial symbols without pulsing err.
REQ-025 If led_in is high as reset deasserts, that pulse SHALL be treated as a new MARK from its first sampled high cycle.

Structure
REQ-026 The shared package morse_pkg SHALL hold the state enum, the letter code table (length and pattern per index), and the threshold multipliers (1/2, 2, 3, 4, 5).
REQ-027 The code-to-letter lookup SHALL be a combinational sub-module morse_lut with inputs count and pattern and outputs letter and hit.
REQ-028 The RTL SHALL be 120-400 lines in total.

Verification (UNIT_CYCLES=10)
REQ-029 Encoder with SW=000 started, decoder attached -> valid pulses once with letter=0 (A), 32 cycles after the final fall.
REQ-030 Drive high 10 / low 10 / high 10 / low 10 / high 10 / low 10 / high 10 / low 30 -> letter=7 (H).
REQ-031 Drive a high pulse of 41 cycles -> err pulses at cycle 41 of the high; no valid follows until 30 low cycles have passed.
REQ-032 Drive five dots -> err on the fifth fall; drive a 3-cycle high glitch -> err.
REQ-033 Assert reset mid-dash, then drive a dot and 30 low cycles -> letter=4 (E), with no err.
REQ-034 Loop all SW values 0..7 through the encoder -> letters 0..7 decoded in order, no err.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse light-stream decoder.
// Contents: FSM state enum, letter code table (symbol count + pattern per
// letter index), and timing threshold multipliers applied to UNIT_CYCLES.
package morse_pkg;

  localparam int unsigned LETTER_W    = 3;
  localparam int unsigned PAT_W       = 4;
  localparam int unsigned SYM_CNT_W   = 3;
  localparam int unsigned NUM_LETTERS = 8;
  localparam int unsigned MAX_SYMS    = 4;

  // Threshold multipliers of one time unit
  localparam int unsigned HALF_DIV      = 2;  // shortest legal mark is UNIT/2
  localparam int unsigned DOT_MAX_MULT  = 2;  // marks below 2*UNIT are dots
  localparam int unsigned GAP_MULT      = 3;  // letter gap / error recovery
  localparam int unsigned DASH_MAX_MULT = 4;  // longest legal dash
  localparam int unsigned SAT_MULT      = 5;  // level counter saturation

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Patterns are right-aligned: first symbol lands in bit len-1, dash = 1
  typedef struct packed {
    logic [SYM_CNT_W-1:0] len;
    logic [PAT_W-1:0]     pat;
  } code_t;

  localparam code_t CODE_TABLE [NUM_LETTERS] = '{
    '{len: 3'd2, pat: 4'b0001},  // A .-
    '{len: 3'd4, pat: 4'b1000},  // B -...
    '{len: 3'd4, pat: 4'b1010},  // C -.-.
    '{len: 3'd3, pat: 4'b0100},  // D -..
    '{len: 3'd1, pat: 4'b0000},  // E .
    '{len: 3'd4, pat: 4'b0010},  // F ..-.
    '{len: 3'd3, pat: 4'b0110},  // G --.
    '{len: 3'd4, pat: 4'b0000}   // H ....
  };

endpackage

// File: rtl/morse_lut.sv
// Combinational code-to-letter lookup.
// Ports: count/pattern (collected symbols) in; letter (index 0=A..7=H)
// and hit (pair is a known letter) out.
module morse_lut
  import morse_pkg::*;
(
  input  logic [SYM_CNT_W-1:0] count,
  input  logic [PAT_W-1:0]     pattern,
  output logic [LETTER_W-1:0]  letter,
  output logic                 hit
);

  // First matching table entry wins; entries are unique anyway
  always_comb begin
    letter = '0;
    hit    = 1'b0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (!hit && count == CODE_TABLE[i].len && pattern == CODE_TABLE[i].pat) begin
        hit    = 1'b1;
        letter = LETTER_W'(i);
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse light-stream decoder for letters A..H.
// Ports: clk, reset (sync, active high), led_in (light stream);
// letter (last decoded index), valid / err (one-cycle pulses),
// busy (FSM not idle).
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                led_in,
  output logic [LETTER_W-1:0] letter,
  output logic                valid,
  output logic                err,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(SAT_MULT * UNIT_CYCLES + 2);

  localparam logic [CNT_W-1:0] T_DOT_MIN  = CNT_W'(UNIT_CYCLES / HALF_DIV);
  localparam logic [CNT_W-1:0] T_DOT_MAX  = CNT_W'(DOT_MAX_MULT * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_GAP      = CNT_W'(GAP_MULT * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_DASH_MAX = CNT_W'(DASH_MAX_MULT * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] T_SAT      = CNT_W'(SAT_MULT * UNIT_CYCLES);

  state_e               state_q, state_d;
  logic                 led_q, led_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAT_W-1:0]     pattern_q, pattern_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [LETTER_W-1:0]  letter_q, letter_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic [CNT_W-1:0]     mark_len_c;
  logic                 space_done_c;
  logic [LETTER_W-1:0]  lut_letter;
  logic                 lut_hit;

  // cnt_q holds completed cycles at the current led_q level; led_in is the
  // next led_q value, so a pending edge is decided while the old length is
  // still intact and mark_len_c includes the current (last) high cycle.
  assign mark_len_c   = cnt_q + CNT_W'(1);
  assign space_done_c = (cnt_q >= T_GAP);

  morse_lut u_lut (
    .count   (sym_cnt_q),
    .pattern (pattern_q),
    .letter  (lut_letter),
    .hit     (lut_hit)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      led_q     <= 1'b0;
      cnt_q     <= '0;
      pattern_q <= '0;
      sym_cnt_q <= '0;
      letter_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      sym_cnt_q <= sym_cnt_d;
      letter_q  <= letter_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (led_in) state_d = ST_MARK;
      end
      ST_MARK: begin
        if (!led_in) begin
          if (mark_len_c < T_DOT_MIN)                 state_d = ST_ERR;
          else if (sym_cnt_q == SYM_CNT_W'(MAX_SYMS)) state_d = ST_ERR;
          else                                        state_d = ST_SPACE;
        end else if (mark_len_c >= T_DASH_MAX) begin
          // Staying high one more cycle would exceed the longest dash
          state_d = ST_ERR;
        end
      end
      ST_SPACE: begin
        if (space_done_c)  state_d = ST_IDLE;
        else if (led_in)   state_d = ST_MARK;
      end
      ST_ERR: begin
        if (!led_q && space_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    led_d     = led_in;
    cnt_d     = (led_in != led_q) ? '0 :
                (cnt_q >= T_SAT)  ? cnt_q : cnt_q + CNT_W'(1);
    pattern_d = pattern_q;
    sym_cnt_d = sym_cnt_q;
    letter_d  = letter_q;
    valid_d   = 1'b0;
    err_d     = (state_d == ST_ERR) && (state_q != ST_ERR);
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_MARK) begin
          pattern_d = '0;
          sym_cnt_d = '0;
        end
      end
      ST_MARK: begin
        if (state_d == ST_SPACE) begin
          pattern_d = {pattern_q[PAT_W-2:0], (mark_len_c >= T_DOT_MAX)};
          sym_cnt_d = sym_cnt_q + SYM_CNT_W'(1);
        end
      end
      ST_SPACE: begin
        if (state_d == ST_IDLE) begin
          if (lut_hit) begin
            letter_d = lut_letter;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign letter = letter_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with UNIT_CYCLES=10; drives encoder-style
// light streams and checks decoded letters, error pulses and latency.
module tb_morse_decoder;

  localparam int UNIT = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       led_in;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int edge_n     = 0;
  int valid_cnt  = 0;
  int err_cnt    = 0;
  int both_cnt   = 0;
  int valid_edge = 0;
  int err_edge   = 0;
  int fall_edge  = 0;
  int rise_edge  = 0;
  int v0, e0;

  string MORSE [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_decoder #(.UNIT_CYCLES(UNIT)) dut (
    .clk    (clk),
    .reset  (reset),
    .led_in (led_in),
    .letter (letter),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt  = valid_cnt + 1;
      valid_edge = edge_n;
    end
    if (err) begin
      err_cnt  = err_cnt + 1;
      err_edge = edge_n;
    end
    if (valid && err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive led_in to v for n sampled cycles, returning 1 time unit after an edge
  task automatic hold(input logic v, input int n);
    led_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Encoder timing: dot 1 unit, dash 3 units, 1 unit between symbols
  task automatic send_letter(input int idx);
    string s;
    s = MORSE[idx];
    for (int i = 0; i < s.len(); i++) begin
      if (i > 0) hold(1'b0, UNIT);
      hold(1'b1, (s[i] == "-") ? 3 * UNIT : UNIT);
    end
    fall_edge = edge_n;
    hold(1'b0, 4 * UNIT);
  endtask

  initial begin
    reset  = 1'b1;
    led_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_letter", 32'(letter), 0);
    check("reset_valid",  32'(valid), 0);
    check("reset_err",    32'(err), 0);
    check("reset_busy",   32'(busy), 0);
    reset = 1'b0;
    hold(1'b0, 2);

    // Letter A from the encoder
    v0 = valid_cnt; e0 = err_cnt;
    send_letter(0);
    check("a_valid_cnt", 32'(valid_cnt - v0), 1);
    check("a_letter",    32'(letter), 0);
    check("a_latency",   32'(valid_edge - fall_edge), 32);
    check("a_no_err",    32'(err_cnt - e0), 0);

    // Raw vector for H
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 5);
    check("h_busy_mark", 32'(busy), 1);
    hold(1'b1, 5);
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, UNIT);
      hold(1'b1, UNIT);
    end
    fall_edge = edge_n;
    hold(1'b0, 4 * UNIT);
    check("h_valid_cnt", 32'(valid_cnt - v0), 1);
    check("h_letter",    32'(letter), 7);
    check("h_latency",   32'(valid_edge - fall_edge), 32);
    check("h_busy_idle", 32'(busy), 0);

    // Over-long mark: error at high cycle 41, recovery after 3 units low
    v0 = valid_cnt; e0 = err_cnt;
    rise_edge = edge_n;
    hold(1'b1, 41);
    hold(1'b0, 29);
    check("long_err_cnt",   32'(err_cnt - e0), 1);
    check("long_err_cycle", 32'(err_edge - rise_edge), 41);
    check("long_busy_wait", 32'(busy), 1);
    hold(1'b0, 10);
    check("long_busy_idle", 32'(busy), 0);
    check("long_no_valid",  32'(valid_cnt - v0), 0);
    check("long_letter",    32'(letter), 7);

    // Five dots: error on the fifth fall
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, UNIT);
      if (i == 4) fall_edge = edge_n;
      hold(1'b0, (i == 4) ? 4 * UNIT : UNIT);
    end
    check("five_err_cnt",  32'(err_cnt - e0), 1);
    check("five_err_edge", 32'(err_edge - fall_edge), 1);
    check("five_no_valid", 32'(valid_cnt - v0), 0);

    // Short glitch
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 3);
    hold(1'b0, 4 * UNIT);
    check("glitch_err_cnt",  32'(err_cnt - e0), 1);
    check("glitch_no_valid", 32'(valid_cnt - v0), 0);

    // Well-formed but unknown code (.-..) fails at lookup
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, UNIT);     hold(1'b0, UNIT);
    hold(1'b1, 3 * UNIT); hold(1'b0, UNIT);
    hold(1'b1, UNIT);     hold(1'b0, UNIT);
    hold(1'b1, UNIT);
    fall_edge = edge_n;
    hold(1'b0, 4 * UNIT);
    check("miss_err_cnt",  32'(err_cnt - e0), 1);
    check("miss_latency",  32'(err_edge - fall_edge), 32);
    check("miss_no_valid", 32'(valid_cnt - v0), 0);

    // Reset mid-dash, led_in still high across release: decodes as E
    v0 = valid_cnt; e0 = err_cnt;
    hold(1'b1, 15);
    reset = 1'b1;
    hold(1'b1, 2);
    check("rst_letter", 32'(letter), 0);
    check("rst_busy",   32'(busy), 0);
    reset = 1'b0;
    hold(1'b1, UNIT);
    fall_edge = edge_n;
    hold(1'b0, 4 * UNIT);
    check("rst_e_letter",  32'(letter), 4);
    check("rst_e_valid",   32'(valid_cnt - v0), 1);
    check("rst_e_latency", 32'(valid_edge - fall_edge), 32);
    check("rst_no_err",    32'(err_cnt - e0), 0);

    // All encoder letters in order
    for (int idx = 0; idx < 8; idx++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_letter(idx);
      check($sformatf("enc%0d_letter", idx), 32'(letter), 32'(idx));
      check($sformatf("enc%0d_valid", idx),  32'(valid_cnt - v0), 1);
      check($sformatf("enc%0d_no_err", idx), 32'(err_cnt - e0), 0);
    end

    check("valid_err_overlap", 32'(both_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
